generatore_sync: RTL

Raster timing generator for the 1280×1024 @ 60 Hz display path.
- Produces the scan coordinates X_CONTROLLO / Y_CONTROLLO consumed by every shape hit-tester (rectangle, frame), plus HSYNC/VSYNC, the visible-area flag and an end-of-frame strobe.
- Movers use the end-of-frame strobe to update object positions during vertical blanking.
- Sits between the pixel clock domain input and all drawing logic.

---
 rtl/generatore_sync_pkg.sv | 32 +++
 rtl/generatore_sync_contatore_asse.sv | 31 +++
 rtl/generatore_sync.sv | 95 +++++++++
 3 files changed

// File: rtl/generatore_sync_pkg.sv
// Shared raster timing constants for the 1280x1024@60 display path.
// Hit-testers and the timing generator take their H/V geometry from here.
package generatore_sync_pkg;

  localparam int unsigned CW = 11;
  localparam int unsigned MAX_TOT = 2048;

  localparam int unsigned H_DEF      = 1280;
  localparam int unsigned H_FP_DEF   = 48;
  localparam int unsigned H_SYNC_DEF = 112;
  localparam int unsigned H_BP_DEF   = 248;
  localparam int unsigned V_DEF      = 1024;
  localparam int unsigned V_FP_DEF   = 1;
  localparam int unsigned V_SYNC_DEF = 3;
  localparam int unsigned V_BP_DEF   = 38;

  typedef logic [CW-1:0] coord_t;

  function automatic int unsigned totale(input int unsigned att, input int unsigned fp,
                                         input int unsigned sy, input int unsigned bp);
    return att + fp + sy + bp;
  endfunction

  localparam int unsigned H_TOT_DEF = totale(H_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOT_DEF = totale(V_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  localparam int unsigned HS_START_DEF = H_DEF + H_FP_DEF;
  localparam int unsigned HS_END_DEF   = H_DEF + H_FP_DEF + H_SYNC_DEF - 1;
  localparam int unsigned VS_START_DEF = V_DEF + V_FP_DEF;
  localparam int unsigned VS_END_DEF   = V_DEF + V_FP_DEF + V_SYNC_DEF - 1;

endpackage

// File: rtl/generatore_sync_contatore_asse.sv
// One raster axis counter: counts 0..MOD-1 on enable, exposes next value and wrap.
// Resets to MOD-1 so the first enabled edge lands on 0.
module contatore_asse
  import generatore_sync_pkg::*;
#(
  parameter int unsigned MOD = H_TOT_DEF
) (
  input  logic   CLK,
  input  logic   RST_N,
  input  logic   i_en,
  output coord_t o_next,
  output logic   o_wrap
);

  localparam coord_t LAST = CW'(MOD - 1);

  coord_t r_cnt;

  assign o_wrap = i_en && (r_cnt == LAST);

  always_comb begin
    o_next = r_cnt;
    if (i_en) o_next = o_wrap ? '0 : r_cnt + CW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_cnt <= LAST;
    else        r_cnt <= o_next;
  end

endmodule

// File: rtl/generatore_sync.sv
// Raster timing generator: scan coordinates, HSYNC/VSYNC, visible flag, end-of-frame strobe.
// Flags are derived from the next counter value so they align with the registered coordinate.
module generatore_sync
  import generatore_sync_pkg::*;
#(
  parameter int unsigned H      = H_DEF,
  parameter int unsigned H_FP   = H_FP_DEF,
  parameter int unsigned H_SYNC = H_SYNC_DEF,
  parameter int unsigned H_BP   = H_BP_DEF,
  parameter int unsigned V      = V_DEF,
  parameter int unsigned V_FP   = V_FP_DEF,
  parameter int unsigned V_SYNC = V_SYNC_DEF,
  parameter int unsigned V_BP   = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          PIXEL_EN,
  output logic [CW-1:0] X_CONTROLLO,
  output logic [CW-1:0] Y_CONTROLLO,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          VISIBILE,
  output logic          FINE_QUADRO
);

  localparam int unsigned H_TOT = totale(H, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOT = totale(V, V_FP, V_SYNC, V_BP);

  localparam coord_t H_L      = CW'(H);
  localparam coord_t V_L      = CW'(V);
  localparam coord_t HS_START = CW'(H + H_FP);
  localparam coord_t HS_END   = CW'(H + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = CW'(V + V_FP);
  localparam coord_t VS_END   = CW'(V + V_FP + V_SYNC - 1);

  if (H_TOT > MAX_TOT || V_TOT > MAX_TOT) begin : g_tot_check
    $error("generatore_sync: H_TOT=%0d V_TOT=%0d exceed %0d", H_TOT, V_TOT, MAX_TOT);
  end

  coord_t w_nx;
  coord_t w_ny;
  logic   w_hwrap;
  logic   w_vwrap_unused;

  contatore_asse #(.MOD(H_TOT)) u_cnt_h (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_en   (PIXEL_EN),
    .o_next (w_nx),
    .o_wrap (w_hwrap)
  );

  contatore_asse #(.MOD(V_TOT)) u_cnt_v (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_en   (w_hwrap),
    .o_next (w_ny),
    .o_wrap (w_vwrap_unused)
  );

  logic w_hs_act;
  logic w_vs_act;
  logic w_vis;
  logic w_fine;

  always_comb begin
    w_hs_act = (w_nx >= HS_START) && (w_nx <= HS_END);
    w_vs_act = (w_ny >= VS_START) && (w_ny <= VS_END);
    w_vis    = (w_nx < H_L) && (w_ny < V_L);
    w_fine   = PIXEL_EN && (w_nx == '0) && (w_ny == V_L);
  end

  // FINE_QUADRO is not held with the other outputs: it must drop after one CLK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      X_CONTROLLO <= '0;
      Y_CONTROLLO <= '0;
      HSYNC       <= ~SYNC_POL;
      VSYNC       <= ~SYNC_POL;
      VISIBILE    <= 1'b0;
      FINE_QUADRO <= 1'b0;
    end else begin
      FINE_QUADRO <= w_fine;
      if (PIXEL_EN) begin
        X_CONTROLLO <= w_nx;
        Y_CONTROLLO <= w_ny;
        HSYNC       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
        VSYNC       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
        VISIBILE    <= w_vis;
      end
    end
  end

endmodule
